dma_engine: RTL and testbench
=============================

// Module: dma_engine
// PURPOSE
//  Block-copy DMA controller for the Supervision memory bus (CPU regs 2008-200D).
//  - Copies length*16 bytes from src_addr to dst_addr, one byte at a time: read phase, then write phase.
//  - Top level muxes addr/dout/write onto AB/DO while busy and holds the CPU off via cpu_rdy = ~busy.
//  - done pulse feeds irq_dma.
// PARAMETERS
//  ADDR_W  16  width of src/dst/addr bus; all address arithmetic is modulo 2**ADDR_W
//  RD_LAT  2   cycles from addr valid to din valid (sync RAM + registered DI mux); legal 1..7
// PORTS
//  clk       in   1       system clock; single clock domain
//  reset_n   in   1       synchronous reset, active-low
//  rdy       in   1       bus grant; 0 = video owns VRAM port, engine stalls
//  ctrl      in   8       control reg 200D; bit7 = start, others ignored
//  src_addr  in   ADDR_W  source base {200A,2009}... as wired: {hi,lo}
//  dst_addr  in   ADDR_W  destination base
//  length    in   8       transfer size in 16-byte units; 0 means 256 (4096 bytes)
//  din       in   8       read data from bus mux (valid RD_LAT cycles after addr)
//  addr      out  ADDR_W  bus address while busy
//  dout      out  8       write data
//  write     out  1       1 = write strobe this cycle (one cycle per byte)
//  sel       out  1       1 = engine drives a bus access this cycle
//  busy      out  1       transfer in progress
//  done      out  1       one-cycle pulse after last byte written
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state IDLE.
//   - addr=0, dout=0, write=0, sel=0, busy=0, done=0.
//   - start_prev=1 so a start bit held through reset does not trigger.
//  Start detect:
//   - start_prev <= ctrl[7] every cycle.
//   - Trigger = ctrl[7] & ~start_prev & state==IDLE.
//   - Edges while busy are ignored and do not queue. Level hold never retriggers.
//  On trigger (edge T):
//   - Latch src, dst and byte count N = {length==0, length, 4'b0}, a 13-bit value.
//   - Clear index i. busy=1 from T+1.
//  States: IDLE -> READ -> WRITE -> (READ | FIN) -> IDLE.
//   - READ: addr=src+i, sel=1, write=0, for RD_LAT+1 cycles (wait counter).
//     din is latched into data reg on the final READ edge.
//   - WRITE: addr=dst+i, dout=data, write=1, sel=1 for exactly 1 cycle. Then i<=i+1.
//     If i+1==N -> FIN, else READ.
//   - FIN: busy=0, done=1 for one cycle, then IDLE. busy and done are never both 1.
//  Throughput: (RD_LAT+2) cycles/byte. Busy for N*(RD_LAT+2) cycles when rdy stays 1.
//  Stall:
//   - While rdy=0: state, wait counter and i frozen; sel=0, write=0; addr holds value.
//   - A WRITE cycle with rdy=0 is not counted and is reissued when rdy returns.
//   - A READ phase interrupted by rdy=0 restarts its wait counter (din is not trusted across a stall).
//  Address wrap: src+i, dst+i wrap modulo 2**ADDR_W; no error, no stop.
//  Overlap src/dst: strictly ascending byte order; no overlap correction.
//  Reset mid-transfer: abort immediately to reset values; no done pulse.
//  ctrl/src/dst/length changes during busy: no effect (latched at trigger).
// TESTING
//  - length=1, src=0x0100 (bytes 0..15), dst=0x4000, rdy=1
//    -> 16 write pulses at 0x4000..0x400F with data 0..15; busy 64 cycles; one done pulse.
//  - length=0 -> 4096 write pulses, busy 16384 cycles, last write addr dst+0x0FFF.
//  - length=1, rdy=0 for 10 cycles starting on 3rd WRITE cycle
//    -> no write during stall; that byte rewritten after stall; busy extends to >=74 cycles; data intact.
//  - src=0xFFF8, dst=0x4000, length=1 -> reads 0xFFF8..0xFFFF then 0x0000..0x0007; 16 writes correct.
//  - reset_n=0 at byte 5 -> next cycle busy=0, write=0, no done.
//    ctrl[7] still 1 after reset -> no new transfer until 0 then 1.
//  - ctrl[7] 0->1 while busy and held 1 after done
//    -> exactly one transfer; a fresh 0->1 edge after IDLE starts a second one.

Source files
------------

// File: rtl/dma_engine.sv
// Block-copy DMA engine: copies N = length*16 bytes (length 0 = 4096) from src to dst, one byte at a time.
// Latency: trigger edge -> busy next cycle; (RD_LAT+2) cycles per byte; done pulses one cycle after the last write.
// Backpressure: i_rdy=0 freezes the engine (no sel/write); a stalled WRITE is reissued and a stalled READ restarts its wait.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_rdy                     bus grant; 0 stalls the engine
//   i_ctrl                    control register; bit 7 rising edge starts a transfer
//   i_src_addr, i_dst_addr    source / destination base addresses (latched at trigger)
//   i_length                  transfer size in 16-byte units (latched at trigger)
//   i_din                     read data, valid RD_LAT cycles after the address
//   o_addr, o_dout, o_write   bus address, write data, write strobe
//   o_sel                     engine owns the bus this cycle
//   o_busy, o_done            transfer in progress, one-cycle completion pulse
module dma_engine #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rdy,
  input  logic [7:0]        i_ctrl,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [7:0]        i_length,
  input  logic [7:0]        i_din,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_dout,
  output logic              o_write,
  output logic              o_sel,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_start_prev;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [12:0]       r_cnt;
  logic [12:0]       r_idx;
  logic [2:0]        r_wait;
  logic [7:0]        r_data;

  logic              w_trigger;
  logic              w_last_wait;
  logic [12:0]       w_idx_inc;
  logic              w_unused_ctrl;

  // Only bit 7 of the control register has meaning here.
  assign w_unused_ctrl = &{1'b0, i_ctrl[6:0]};

  assign w_trigger   = i_ctrl[7] & ~r_start_prev & (r_state == S_IDLE);
  assign w_last_wait = (r_wait == 3'(RD_LAT));
  assign w_idx_inc   = r_idx + 13'd1;
  assign o_dout      = r_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      // Starts high so a start bit held through reset is not seen as an edge.
      r_start_prev <= 1'b1;
      r_src        <= '0;
      r_dst        <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_wait       <= '0;
      r_data       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_prev <= i_ctrl[7];
      if (w_trigger) begin
        r_src  <= i_src_addr;
        r_dst  <= i_dst_addr;
        // length 0 encodes 256 units, so the count needs the extra top bit.
        r_cnt  <= {(i_length == 8'd0), i_length, 4'b0000};
        r_idx  <= '0;
        r_wait <= '0;
      end
      case (r_state)
        S_READ: begin
          // Data in flight is not trusted across a stall: restart the wait.
          if (!i_rdy) begin
            r_wait <= '0;
          end else if (w_last_wait) begin
            r_wait <= '0;
            r_data <= i_din;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_WRITE: begin
          if (i_rdy) r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_addr      = '0;
    o_write     = 1'b0;
    o_sel       = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) w_state_nxt = S_READ;
      end
      S_READ: begin
        o_busy = 1'b1;
        o_addr = r_src + ADDR_W'(r_idx);
        o_sel  = i_rdy;
        if (i_rdy && w_last_wait) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_busy  = 1'b1;
        o_addr  = r_dst + ADDR_W'(r_idx);
        o_sel   = i_rdy;
        o_write = i_rdy;
        if (i_rdy) w_state_nxt = (w_idx_inc == r_cnt) ? S_FIN : S_READ;
      end
      S_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_engine.sv
module tb_dma_engine;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam int BPC    = RD_LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [7:0]  ctrl;
  logic [15:0] src_i;
  logic [15:0] dst_i;
  logic [7:0]  len_i;
  logic [7:0]  din;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        wr;
  logic        sel;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dma_engine #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rdy(rdy), .i_ctrl(ctrl),
    .i_src_addr(src_i), .i_dst_addr(dst_i), .i_length(len_i), .i_din(din),
    .o_addr(addr), .o_dout(dout), .o_write(wr), .o_sel(sel),
    .o_busy(busy), .o_done(done)
  );

  // Bus memory: read data appears RD_LAT cycles after the address.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] pipe    [RD_LAT];

  always @(posedge clk) begin
    pipe[0] <= addr;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign din = mem[pipe[RD_LAT-1]];

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] obs_a[$];
  logic [7:0]  obs_d[$];
  logic [15:0] exp_a[$];
  logic [7:0]  exp_d[$];
  int obs_busy, obs_done, obs_both, obs_stallacc;

  task automatic clear_obs();
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    obs_busy = 0; obs_done = 0; obs_both = 0; obs_stallacc = 0;
  endtask

  // Records one cycle of bus activity; a write lands in memory (reads of it come later).
  task automatic sample_cycle();
    if (wr) begin
      obs_a.push_back(addr);
      obs_d.push_back(dout);
      mem[addr] = dout;
    end
    if (busy) obs_busy++;
    if (done) obs_done++;
    if (busy && done) obs_both++;
    if (!rdy && (sel || wr)) obs_stallacc++;
  endtask

  // One complete transfer. extra >= 0: busy must equal N*BPC+extra; extra < 0: busy >= N*BPC.
  task automatic run_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len,
                          input int st_from, input int st_len, input bit rnd, input bit retrig,
                          input int extra, input string name);
    int n, limit, post, m, bad;
    logic [15:0] a;
    logic [7:0]  d;
    n = (len == 8'd0) ? 4096 : int'(len) * 16;
    clear_obs();
    // Reference: strictly ascending byte-by-byte copy on a snapshot of memory.
    ref_mem = mem;
    for (int k = 0; k < n; k++) begin
      a = dst + 16'(k);
      d = ref_mem[src + 16'(k)];
      ref_mem[a] = d;
      exp_a.push_back(a);
      exp_d.push_back(d);
    end
    @(negedge clk); ctrl = 8'h00; rdy = 1'b1;
    @(negedge clk); src_i = src; dst_i = dst; len_i = len; ctrl = 8'h80;
    limit = n * BPC * 8 + st_len + 200;
    post = -1;
    for (int c = 0; c < limit && post != 0; c++) begin
      @(negedge clk);
      if (c == 3) begin src_i = 16'($urandom); dst_i = 16'($urandom); len_i = 8'($urandom); end
      if (retrig) begin
        if (c == 5) ctrl = 8'h00;
        else if (c == 7) ctrl = 8'h80;
      end
      rdy = rnd ? ($urandom_range(0, 7) != 0) : !(c >= st_from && c < st_from + st_len);
      #1;
      sample_cycle();
      if (post > 0) post--;
      else if (post < 0 && done) post = 30;
    end
    rdy = 1'b1;
    n_vec++;
    if (obs_a.size() != n) begin
      n_err++; $display("FAIL %s write_count: got %0d expected %0d", name, obs_a.size(), n);
    end
    m = (obs_a.size() < n) ? obs_a.size() : n;
    for (int k = 0; k < m; k++) begin
      n_vec++;
      if (obs_a[k] !== exp_a[k] || obs_d[k] !== exp_d[k]) begin
        n_err++;
        $display("FAIL %s write[%0d]: got addr %h data %h expected addr %h data %h",
                 name, k, obs_a[k], obs_d[k], exp_a[k], exp_d[k]);
      end
    end
    n_vec++;
    if (extra >= 0) begin
      if (obs_busy != n * BPC + extra) begin
        n_err++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, obs_busy, n * BPC + extra);
      end
    end else if (obs_busy < n * BPC) begin
      n_err++; $display("FAIL %s busy_cycles: got %0d expected >= %0d", name, obs_busy, n * BPC);
    end
    n_vec++;
    if (obs_done != 1) begin
      n_err++; $display("FAIL %s done_pulses: got %0d expected 1", name, obs_done);
    end
    n_vec++;
    if (obs_both != 0 || obs_stallacc != 0) begin
      n_err++; $display("FAIL %s protocol: busy&done %0d access-while-stalled %0d expected 0/0",
                        name, obs_both, obs_stallacc);
    end
    bad = 0;
    for (int k = 0; k < 65536; k++) if (mem[k] !== ref_mem[k]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL %s memory_image: got %0d differing bytes expected 0", name, bad);
    end
  endtask

  task automatic test_reset();
    int b;
    rst_n = 1'b0; rdy = 1'b1; ctrl = 8'h80;
    src_i = 16'h1234; dst_i = 16'h5678; len_i = 8'd1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_vec++; if (addr !== 16'h0) begin n_err++; $display("FAIL reset addr: got %h expected 0000", addr); end
    n_vec++; if (dout !== 8'h0)  begin n_err++; $display("FAIL reset dout: got %h expected 00", dout); end
    n_vec++; if ({wr, sel, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset strobes: got wr/sel/busy/done %b expected 0000", {wr, sel, busy, done});
    end
    // Start bit held through reset must not start a transfer.
    rst_n = 1'b1;
    b = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (busy || done || sel) b++;
    end
    n_vec++; if (b != 0) begin n_err++; $display("FAIL reset_held_start: got %0d active cycles expected 0", b); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) mem[16'h0100 + k] = 8'(k);
    run_xfer(16'h0100, 16'h4000, 8'd1, 0, 0, 1'b0, 1'b0, 0, "basic");
  endtask

  task automatic test_stall();
    // Third write cycle is cycle 2*BPC+RD_LAT+1 after the trigger; stall 10 cycles there.
    run_xfer(16'h0300, 16'h5000, 8'd1, 2 * BPC + RD_LAT + 1, 10, 1'b0, 1'b0, 10, "stall_write");
    run_xfer(16'h0600, 16'h5800, 8'd1, 1, 2, 1'b0, 1'b0, 3, "stall_read");
  endtask

  task automatic test_wrap();
    run_xfer(16'hFFF8, 16'h4000, 8'd1, 0, 0, 1'b0, 1'b0, 0, "src_wrap");
    run_xfer(16'h7000, 16'hFFFA, 8'd1, 0, 0, 1'b0, 1'b0, 0, "dst_wrap");
  endtask

  task automatic test_reset_mid();
    clear_obs();
    @(negedge clk); ctrl = 8'h00; rdy = 1'b1;
    @(negedge clk); src_i = 16'h0800; dst_i = 16'h6000; len_i = 8'd1; ctrl = 8'h80;
    // Byte 5 begins at cycle 5*BPC after the trigger.
    for (int c = 0; c < 5 * BPC; c++) begin @(negedge clk); #1; sample_cycle(); end
    n_vec++; if (obs_a.size() != 5) begin
      n_err++; $display("FAIL reset_mid writes_before: got %0d expected 5", obs_a.size());
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #1;
    n_vec++; if ({busy, wr, sel, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_mid outputs: got busy/wr/sel/done %b expected 0000", {busy, wr, sel, done});
    end
    @(negedge clk); rst_n = 1'b1;
    clear_obs();
    for (int c = 0; c < 40; c++) begin @(negedge clk); #1; sample_cycle(); end
    n_vec++; if (obs_busy != 0 || obs_done != 0 || obs_a.size() != 0) begin
      n_err++; $display("FAIL reset_mid after: got busy %0d done %0d writes %0d expected 0/0/0",
                        obs_busy, obs_done, obs_a.size());
    end
    run_xfer(16'h0900, 16'h6100, 8'd1, 0, 0, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_retrigger();
    run_xfer(16'h0A00, 16'h6200, 8'd1, 0, 0, 1'b0, 1'b1, 0, "edge_while_busy");
    run_xfer(16'h0B00, 16'h6300, 8'd2, 0, 0, 1'b0, 1'b0, 0, "fresh_edge");
  endtask

  task automatic test_random();
    run_xfer(16'h2000, 16'h2005, 8'd1, 0, 0, 1'b0, 1'b0, 0, "overlap_fwd");
    run_xfer(16'h2105, 16'h2100, 8'd1, 0, 0, 1'b1, 1'b0, -1, "overlap_back_stall");
    for (int t = 0; t < 4; t++)
      run_xfer(16'($urandom), 16'($urandom), 8'($urandom_range(1, 4)), 0, 0, 1'b1, 1'b0, -1, "random");
  endtask

  task automatic test_len0();
    run_xfer(16'h8000, 16'hC000, 8'd0, 0, 0, 1'b0, 1'b0, 0, "len0");
    n_vec++;
    if (obs_a.size() > 0 && obs_a[obs_a.size()-1] !== 16'hCFFF) begin
      n_err++; $display("FAIL len0 last_addr: got %h expected CFFF", obs_a[obs_a.size()-1]);
    end
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_retrigger();
    test_random();
    test_len0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
